// File: rtl/udp_fb_writer_pkg.sv
// Shared types and constants for the UDP framebuffer writer: FSM states,
// command codes, header field positions and default filter values.
package udp_fb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DROP = 2'd3
  } state_e;

  localparam logic [7:0] CMD_PIXELS = 8'h01;
  localparam logic [7:0] CMD_BRIGHT = 8'h02;
  localparam logic [7:0] CMD_COMMIT = 8'h03;

  localparam int HDR_MAGIC_MSB = 31;
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_CMD_MSB   = 23;
  localparam int HDR_CMD_LSB   = 16;
  localparam int HDR_ARG_MSB   = 15;
  localparam int HDR_ARG_LSB   = 0;

  localparam logic [7:0]  DEFAULT_MAGIC    = 8'hA5;
  localparam logic [15:0] DEFAULT_UDP_PORT = 16'd6454;

  function automatic logic [7:0] hdrMagic(input logic [31:0] word);
    return word[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
  endfunction

  function automatic logic [7:0] hdrCmd(input logic [31:0] word);
    return word[HDR_CMD_MSB:HDR_CMD_LSB];
  endfunction

  function automatic logic [15:0] hdrArg(input logic [31:0] word);
    return word[HDR_ARG_MSB:HDR_ARG_LSB];
  endfunction

endpackage

// File: rtl/udp_fb_writer.sv
// Filters the UDP stream by port, parses a one-word command header and turns
// pixel payloads, brightness and commit commands into panel-side actions.
module udp_fb_writer
  import udp_fb_pkg::*;
#(
  parameter logic [15:0] UDP_PORT = DEFAULT_UDP_PORT,
  parameter int          ADDR_W   = 14,
  parameter int          FB_DEPTH = 16384,
  parameter logic [7:0]  MAGIC    = DEFAULT_MAGIC
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              udp_source_valid,
  input  logic              udp_source_last,
  output logic              udp_source_ready,
  input  logic [15:0]       udp_source_dst_port,
  input  logic [31:0]       udp_source_data,
  input  logic [3:0]        udp_source_error,
  output logic              fb_wren,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [31:0]       fb_data,
  output logic [3:0]        brightness,
  output logic              frame_commit,
  output logic [15:0]       pkt_ok_count,
  output logic [15:0]       pkt_drop_count
);

  localparam logic [16:0]       DEPTH_EXT = 17'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [3:0]        level_q, level_d;
  logic              bad_q, bad_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        bright_q, bright_d;
  logic              commit_q, commit_d;
  logic [15:0]       ok_q, ok_d;
  logic [15:0]       drop_q, drop_d;

  logic       accept;
  logic       beatErr;
  logic [7:0] hCmd;
  logic [15:0] hArg;
  logic       hdrGood;

  assign accept  = udp_source_valid & resetn;
  assign beatErr = |udp_source_error;
  assign hCmd    = hdrCmd(udp_source_data);
  assign hArg    = hdrArg(udp_source_data);

  // A header is usable only if port, magic, error and command all check out;
  // PIXELS additionally needs a start address inside the framebuffer.
  always_comb begin
    hdrGood = (udp_source_dst_port == UDP_PORT) &&
              (hdrMagic(udp_source_data) == MAGIC) && !beatErr &&
              (((hCmd == CMD_PIXELS) && ({1'b0, hArg} < DEPTH_EXT)) ||
               (hCmd == CMD_BRIGHT) || (hCmd == CMD_COMMIT));
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cmd_q    <= '0;
      level_q  <= '0;
      bad_q    <= 1'b0;
      wren_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      bright_q <= 4'd15;
      commit_q <= 1'b0;
      ok_q     <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      level_q  <= level_d;
      bad_q    <= bad_d;
      wren_q   <= wren_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      bright_q <= bright_d;
      commit_q <= commit_d;
      ok_q     <= ok_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cmd_d    = cmd_q;
    level_d  = level_q;
    bad_d    = bad_q;
    wren_d   = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    bright_d = bright_q;
    commit_d = 1'b0;
    ok_d     = ok_q;
    drop_d   = drop_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          bad_d = 1'b0;
          if (!hdrGood) begin
            if (udp_source_last) drop_d = drop_q + 16'd1;
            else                 state_d = DROP;
          end else if (hCmd == CMD_PIXELS) begin
            addr_d = hArg[ADDR_W-1:0];
            if (udp_source_last) ok_d = ok_q + 16'd1;
            else                 state_d = DATA;
          end else if (udp_source_last) begin
            if (hCmd == CMD_BRIGHT) bright_d = hArg[3:0];
            else                    commit_d = 1'b1;
            ok_d = ok_q + 16'd1;
          end else begin
            cmd_d   = hCmd;
            level_d = hArg[3:0];
            state_d = TAIL;
          end
        end
        TAIL: begin
          if (udp_source_last) begin
            if (bad_q || beatErr) begin
              drop_d = drop_q + 16'd1;
            end else begin
              if (cmd_q == CMD_BRIGHT) bright_d = level_q;
              else                     commit_d = 1'b1;
              ok_d = ok_q + 16'd1;
            end
            state_d = IDLE;
          end else if (beatErr) begin
            bad_d = 1'b1;
          end
        end
        DATA: begin
          if (beatErr) begin
            bad_d = 1'b1;
            if (udp_source_last) begin
              drop_d  = drop_q + 16'd1;
              state_d = IDLE;
            end
          end else begin
            wren_d  = 1'b1;
            waddr_d = addr_q;
            wdata_d = udp_source_data;
            addr_d  = addr_q + 1'b1;
            if (udp_source_last) begin
              if (bad_q) drop_d = drop_q + 16'd1;
              else       ok_d   = ok_q + 16'd1;
              state_d = IDLE;
            end else if (addr_q == LAST_ADDR) begin
              // Framebuffer end reached mid-packet: the rest is discarded and
              // the packet is counted as a drop when its last beat arrives.
              state_d = DROP;
            end
          end
        end
        DROP: begin
          if (udp_source_last) begin
            drop_d  = drop_q + 16'd1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    udp_source_ready = resetn;
    fb_wren          = wren_q;
    fb_addr          = waddr_q;
    fb_data          = wdata_q;
    brightness       = bright_q;
    frame_commit     = commit_q;
    pkt_ok_count     = ok_q;
    pkt_drop_count   = drop_q;
  end

endmodule

// File: tb/tb_udp_fb_writer.sv
// Directed, table-driven bench for udp_fb_writer: each vector is one stream
// beat plus the outputs expected on the cycle after it is presented.
module tb_udp_fb_writer;

  localparam logic [15:0] PORT = 16'd6454;

  typedef struct {
    logic        valid;
    logic        last;
    logic [15:0] port;
    logic [31:0] data;
    logic [3:0]  err;
    logic        eWren;
    logic [13:0] eAddr;
    logic [31:0] eData;
    logic [3:0]  eBright;
    logic        eCommit;
    logic [15:0] eOk;
    logic [15:0] eDrop;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        udp_source_valid = 1'b0;
  logic        udp_source_last = 1'b0;
  logic        udp_source_ready;
  logic [15:0] udp_source_dst_port = '0;
  logic [31:0] udp_source_data = '0;
  logic [3:0]  udp_source_error = '0;
  logic        fb_wren;
  logic [13:0] fb_addr;
  logic [31:0] fb_data;
  logic [3:0]  brightness;
  logic        frame_commit;
  logic [15:0] pkt_ok_count;
  logic [15:0] pkt_drop_count;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  udp_fb_writer dut (
    .clock               (clock),
    .resetn              (resetn),
    .udp_source_valid    (udp_source_valid),
    .udp_source_last     (udp_source_last),
    .udp_source_ready    (udp_source_ready),
    .udp_source_dst_port (udp_source_dst_port),
    .udp_source_data     (udp_source_data),
    .udp_source_error    (udp_source_error),
    .fb_wren             (fb_wren),
    .fb_addr             (fb_addr),
    .fb_data             (fb_data),
    .brightness          (brightness),
    .frame_commit        (frame_commit),
    .pkt_ok_count        (pkt_ok_count),
    .pkt_drop_count      (pkt_drop_count)
  );

  always #4 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic v, input logic l, input logic [15:0] p,
                        input logic [31:0] d, input logic [3:0] e,
                        input logic ew, input logic [13:0] ea, input logic [31:0] ed,
                        input logic [3:0] eb, input logic ec,
                        input logic [15:0] eo, input logic [15:0] edr);
    vec_t x;
    x.valid = v; x.last = l; x.port = p; x.data = d; x.err = e;
    x.eWren = ew; x.eAddr = ea; x.eData = ed; x.eBright = eb;
    x.eCommit = ec; x.eOk = eo; x.eDrop = edr;
    vecs.push_back(x);
  endtask

  // Drive one beat at a falling edge, then look at the result one edge later.
  task automatic applyStimulus(input vec_t x, input int idx);
    string tag;
    udp_source_valid    = x.valid;
    udp_source_last     = x.last;
    udp_source_dst_port = x.port;
    udp_source_data     = x.data;
    udp_source_error    = x.err;
    @(negedge clock);
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, " fb_wren"}, 32'(fb_wren), 32'(x.eWren));
    if (x.eWren) begin
      checkOutput({tag, " fb_addr"}, 32'(fb_addr), 32'(x.eAddr));
      checkOutput({tag, " fb_data"}, fb_data, x.eData);
    end
    checkOutput({tag, " brightness"}, 32'(brightness), 32'(x.eBright));
    checkOutput({tag, " frame_commit"}, 32'(frame_commit), 32'(x.eCommit));
    checkOutput({tag, " ok_count"}, 32'(pkt_ok_count), 32'(x.eOk));
    checkOutput({tag, " drop_count"}, 32'(pkt_drop_count), 32'(x.eDrop));
  endtask

  initial begin
    //        v  l  port    data          err   wren addr      data          br  cm ok drop
    addVec(1, 0, PORT,  32'hA5010010, 4'h0, 0, 14'h0,    32'h0,        15, 0, 0, 0);
    addVec(1, 0, 16'h0, 32'h11111111, 4'h0, 1, 14'h0010, 32'h11111111, 15, 0, 0, 0);
    addVec(1, 0, 16'h0, 32'h22222222, 4'h0, 1, 14'h0011, 32'h22222222, 15, 0, 0, 0);
    addVec(1, 1, 16'h0, 32'h33333333, 4'h0, 1, 14'h0012, 32'h33333333, 15, 0, 1, 0);
    addVec(0, 0, PORT,  32'h0,        4'h0, 0, 14'h0,    32'h0,        15, 0, 1, 0);
    addVec(1, 1, PORT,  32'hA5020007, 4'h0, 0, 14'h0,    32'h0,         7, 0, 2, 0);
    addVec(1, 1, PORT,  32'hA5030000, 4'h0, 0, 14'h0,    32'h0,         7, 1, 3, 0);
    addVec(0, 0, PORT,  32'h0,        4'h0, 0, 14'h0,    32'h0,         7, 0, 3, 0);
    addVec(1, 0, 16'd80, 32'hA5010020, 4'h0, 0, 14'h0,   32'h0,         7, 0, 3, 0);
    addVec(1, 1, 16'h0, 32'h44444444, 4'h0, 0, 14'h0,    32'h0,         7, 0, 3, 1);
    addVec(1, 0, PORT,  32'hA5010040, 4'h0, 0, 14'h0,    32'h0,         7, 0, 3, 1);
    addVec(1, 0, 16'h0, 32'h55555555, 4'h0, 1, 14'h0040, 32'h55555555,  7, 0, 3, 1);
    addVec(1, 1, 16'h0, 32'h66666666, 4'h1, 0, 14'h0,    32'h0,         7, 0, 3, 2);
    addVec(1, 0, PORT,  32'hA5013FFE, 4'h0, 0, 14'h0,    32'h0,         7, 0, 3, 2);
    addVec(1, 0, 16'h0, 32'hAAAA0001, 4'h0, 1, 14'h3FFE, 32'hAAAA0001,  7, 0, 3, 2);
    addVec(1, 0, 16'h0, 32'hAAAA0002, 4'h0, 1, 14'h3FFF, 32'hAAAA0002,  7, 0, 3, 2);
    addVec(1, 0, 16'h0, 32'hAAAA0003, 4'h0, 0, 14'h0,    32'h0,         7, 0, 3, 2);
    addVec(1, 1, 16'h0, 32'hAAAA0004, 4'h0, 0, 14'h0,    32'h0,         7, 0, 3, 3);
    addVec(1, 0, PORT,  32'hA5020003, 4'h0, 0, 14'h0,    32'h0,         7, 0, 3, 3);
    addVec(1, 0, 16'h0, 32'h00000000, 4'h0, 0, 14'h0,    32'h0,         7, 0, 3, 3);
    addVec(1, 1, 16'h0, 32'h00000001, 4'h0, 0, 14'h0,    32'h0,         3, 0, 4, 3);
    addVec(1, 0, PORT,  32'hA5020009, 4'h0, 0, 14'h0,    32'h0,         3, 0, 4, 3);
    addVec(1, 0, 16'h0, 32'h00000000, 4'h2, 0, 14'h0,    32'h0,         3, 0, 4, 3);
    addVec(1, 1, 16'h0, 32'h00000001, 4'h0, 0, 14'h0,    32'h0,         3, 0, 4, 4);
    addVec(1, 1, PORT,  32'h5A010000, 4'h0, 0, 14'h0,    32'h0,         3, 0, 4, 5);
    addVec(1, 1, PORT,  32'hA5014000, 4'h0, 0, 14'h0,    32'h0,         3, 0, 4, 6);
    addVec(1, 1, PORT,  32'hA5010005, 4'h0, 0, 14'h0,    32'h0,         3, 0, 5, 6);
    addVec(1, 0, PORT,  32'hA5010100, 4'h0, 0, 14'h0,    32'h0,         3, 0, 5, 6);
    addVec(1, 1, 16'h0, 32'hABCD0001, 4'h0, 1, 14'h0100, 32'hABCD0001,  3, 0, 6, 6);
    addVec(1, 1, PORT,  32'hA5020004, 4'h0, 0, 14'h0,    32'h0,         4, 0, 7, 6);
    addVec(1, 1, PORT,  32'hA5020001, 4'h4, 0, 14'h0,    32'h0,         4, 0, 7, 7);
    addVec(0, 0, PORT,  32'h0,        4'h0, 0, 14'h0,    32'h0,         4, 0, 7, 7);

    // Reset held for three cycles, then released.
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    checkOutput("reset brightness", 32'(brightness), 32'd15);
    checkOutput("reset fb_wren", 32'(fb_wren), 32'd0);
    checkOutput("reset frame_commit", 32'(frame_commit), 32'd0);
    checkOutput("reset ok_count", 32'(pkt_ok_count), 32'd0);
    checkOutput("reset drop_count", 32'(pkt_drop_count), 32'd0);
    checkOutput("reset ready", 32'(udp_source_ready), 32'd1);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Reset in the middle of a pixel packet; the tail then parses as a bad header.
    udp_source_valid = 1'b1; udp_source_last = 1'b0; udp_source_error = '0;
    udp_source_dst_port = PORT; udp_source_data = 32'hA5010200;
    @(negedge clock);
    udp_source_data = 32'hDEADBEEF;
    @(negedge clock);
    checkOutput("midrst pre write", 32'(fb_wren), 32'd1);
    checkOutput("midrst pre addr", 32'(fb_addr), 32'h200);
    udp_source_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    checkOutput("midrst ok_count", 32'(pkt_ok_count), 32'd0);
    checkOutput("midrst drop_count", 32'(pkt_drop_count), 32'd0);
    checkOutput("midrst fb_wren", 32'(fb_wren), 32'd0);
    checkOutput("midrst brightness", 32'(brightness), 32'd15);
    udp_source_valid = 1'b1; udp_source_last = 1'b0; udp_source_data = 32'h12345678;
    @(negedge clock);
    checkOutput("midrst tail0 wren", 32'(fb_wren), 32'd0);
    checkOutput("midrst tail0 drop", 32'(pkt_drop_count), 32'd0);
    udp_source_last = 1'b1; udp_source_data = 32'h9ABCDEF0;
    @(negedge clock);
    checkOutput("midrst tail1 wren", 32'(fb_wren), 32'd0);
    checkOutput("midrst tail1 drop", 32'(pkt_drop_count), 32'd1);
    checkOutput("midrst tail1 ok", 32'(pkt_ok_count), 32'd0);
    udp_source_valid = 1'b0; udp_source_last = 1'b0;
    @(negedge clock);
    checkOutput("midrst idle ready", 32'(udp_source_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
